// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32/RV64 immediate generator with valid/ready handshake,
// optional 2-entry skid buffer and synchronous flush.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int SKID  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]       op;
    logic             is_i;
    logic [2:0]       fmt_d;
    logic [XLEN-1:0]  imm_d;
    logic             o_v, k_v;
    logic [XLEN-1:0]  k_imm;
    logic [2:0]       k_fmt;
    logic [TAG_W-1:0] k_tag;

    always_comb begin
        op    = instr_i[6:0];
        is_i  = op == OP_IMM || op == OP_LOAD || op == OP_JALR || (XLEN == 64 && op == OP_IMM_32);
        fmt_d = is_i ? 3'd1 :
                op == OP_STORE ? 3'd2 :
                op == OP_BRANCH ? 3'd3 :
                (op == OP_LUI || op == OP_AUIPC) ? 3'd4 :
                op == OP_JAL ? 3'd5 :
                (op == OP_SYSTEM && instr_i[14]) ? 3'd6 : 3'd0;
        // Signed casts make the width casts sign-extend to XLEN.
        imm_d = fmt_d == 3'd1 ? XLEN'($signed(instr_i[31:20])) :
                fmt_d == 3'd2 ? XLEN'($signed({instr_i[31:25], instr_i[11:7]})) :
                fmt_d == 3'd3 ? XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0})) :
                fmt_d == 3'd4 ? XLEN'($signed({instr_i[31:12], 12'b0})) :
                fmt_d == 3'd5 ? XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0})) :
                fmt_d == 3'd6 ? XLEN'(instr_i[19:15]) : '0;
    end

    assign in_ready_o  = SKID != 0 ? !k_v : (!o_v || out_ready_i);
    assign out_valid_o = o_v;

    // K is only ever valid while O is held, so a valid K always refills O on drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            o_v   <= 1'b0;
            k_v   <= 1'b0;
            imm_o <= '0;
            fmt_o <= '0;
            tag_o <= '0;
            k_imm <= '0;
            k_fmt <= '0;
            k_tag <= '0;
        end else if (flush_i) begin
            o_v <= 1'b0;
            k_v <= 1'b0;
        end else if (k_v) begin
            if (out_ready_i) begin
                imm_o <= k_imm;
                fmt_o <= k_fmt;
                tag_o <= k_tag;
                k_v   <= 1'b0;
            end
        end else if (in_valid_i && in_ready_o) begin
            if (!o_v || out_ready_i) begin
                o_v   <= 1'b1;
                imm_o <= imm_d;
                fmt_o <= fmt_d;
                tag_o <= tag_i;
            end else if (SKID != 0) begin
                k_v   <= 1'b1;
                k_imm <= imm_d;
                k_fmt <= fmt_d;
                k_tag <= tag_i;
            end
        end else if (out_ready_i) begin
            o_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of imm_gen_stage at XLEN=32/64 with skid, and XLEN=32 without skid.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [4:0]  tag;
    logic        rdy32, v32, rdy64, v64, rdy0, v0;
    logic [31:0] imm32, imm0;
    logic [63:0] imm64;
    logic [2:0]  f32, f64, f0;
    logic [4:0]  t32, t64, t0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(5), .SKID(1)) d32 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .instr_i(instr), .tag_i(tag), .out_valid_o(v32), .out_ready_i(out_ready),
        .imm_o(imm32), .fmt_o(f32), .tag_o(t32));
    imm_gen_stage #(.XLEN(64), .TAG_W(5), .SKID(1)) d64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .instr_i(instr), .tag_i(tag), .out_valid_o(v64), .out_ready_i(out_ready),
        .imm_o(imm64), .fmt_o(f64), .tag_o(t64));
    imm_gen_stage #(.XLEN(32), .TAG_W(5), .SKID(0)) d0 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .instr_i(instr), .tag_i(tag), .out_valid_o(v0), .out_ready_i(out_ready),
        .imm_o(imm0), .fmt_o(f0), .tag_o(t0));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; tag = '0;
        #3;
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL reset_valid32: got %0d want 0", v32); end
        tests++; if (imm32 !== 32'h0) begin fails++; $display("FAIL reset_imm32: got %h want 0", imm32); end
        tests++; if (f32 !== 3'd0) begin fails++; $display("FAIL reset_fmt32: got %0d want 0", f32); end
        tests++; if (t32 !== 5'd0) begin fails++; $display("FAIL reset_tag32: got %0d want 0", t32); end
        tests++; if (rdy32 !== 1'b1) begin fails++; $display("FAIL reset_ready32: got %0d want 1", rdy32); end
        tests++; if (v64 !== 1'b0 || imm64 !== 64'h0) begin fails++; $display("FAIL reset_64: got v=%0d imm=%h want v=0 imm=0", v64, imm64); end
        tests++; if (v0 !== 1'b0 || rdy0 !== 1'b1) begin fails++; $display("FAIL reset_noskid: got v=%0d rdy=%0d want v=0 rdy=1", v0, rdy0); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_addi;
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; tag = 5'd5;
        cyc();
        in_valid = 1'b0;
        tests++; if (v32 !== 1'b1) begin fails++; $display("FAIL addi_valid: got %0d want 1", v32); end
        tests++; if (imm32 !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm32: got %h want ffffffff", imm32); end
        tests++; if (f32 !== 3'd1) begin fails++; $display("FAIL addi_fmt: got %0d want 1", f32); end
        tests++; if (t32 !== 5'd5) begin fails++; $display("FAIL addi_tag: got %0d want 5", t32); end
        tests++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL addi_imm64: got %h want all ones", imm64); end
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL addi_drain: got %0d want 0", v32); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [3] = '{32'hFE112E23, 32'hFFDFF06F, 32'h300FD073};
        logic [31:0] exp [3] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0000001F};
        logic [2:0]  ef  [3] = '{3'd2, 3'd5, 3'd6};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = ins[i]; tag = 5'(i + 1);
            cyc();
            tests++; if (v32 !== 1'b1 || t32 !== 5'(i + 1)) begin fails++; $display("FAIL b2b_order[%0d]: got v=%0d tag=%0d want v=1 tag=%0d", i, v32, t32, i + 1); end
            tests++; if (imm32 !== exp[i] || f32 !== ef[i]) begin fails++; $display("FAIL b2b_imm[%0d]: got %h/%0d want %h/%0d", i, imm32, f32, exp[i], ef[i]); end
            tests++; if (v0 !== 1'b1 || imm0 !== exp[i] || t0 !== 5'(i + 1)) begin fails++; $display("FAIL b2b_noskid[%0d]: got v=%0d imm=%h tag=%0d want 1/%h/%0d", i, v0, imm0, t0, exp[i], i + 1); end
        end
        in_valid = 1'b0;
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL b2b_end: got %0d want 0", v32); end
    endtask

    task automatic test_decode;
        logic [31:0] ins [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h800002B7, 32'h0000006B,
                                 32'hFFF0009B, 32'h30029073, 32'h12345017, 32'h7FF02083};
        logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000, 32'h0,
                                 32'h0, 32'h0, 32'h12345000, 32'h000007FF};
        logic [2:0]  f32e [8] = '{3'd1, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1};
        logic [63:0] e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h0,
                                 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0000000012345000, 64'h00000000000007FF};
        logic [2:0]  f64e [8] = '{3'd1, 3'd3, 3'd4, 3'd0, 3'd1, 3'd0, 3'd4, 3'd1};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr = ins[i]; tag = 5'(i + 8);
            cyc();
            tests++; if (v32 !== 1'b1 || imm32 !== e32[i] || f32 !== f32e[i]) begin fails++; $display("FAIL dec32[%0d]: got v=%0d %h/%0d want 1 %h/%0d", i, v32, imm32, f32, e32[i], f32e[i]); end
            tests++; if (v64 !== 1'b1 || imm64 !== e64[i] || f64 !== f64e[i] || t64 !== 5'(i + 8)) begin fails++; $display("FAIL dec64[%0d]: got v=%0d %h/%0d tag=%0d want 1 %h/%0d tag=%0d", i, v64, imm64, f64, t64, e64[i], f64e[i], i + 8); end
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_skid;
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; tag = 5'd1;
        cyc();
        tests++; if (v32 !== 1'b1 || t32 !== 5'd1 || rdy32 !== 1'b1) begin fails++; $display("FAIL skid_first: got v=%0d tag=%0d rdy=%0d want 1/1/1", v32, t32, rdy32); end
        tests++; if (rdy0 !== 1'b0 || t0 !== 5'd1) begin fails++; $display("FAIL noskid_hold: got rdy=%0d tag=%0d want 0/1", rdy0, t0); end
        tag = 5'd2;
        cyc();
        tests++; if (t32 !== 5'd1 || rdy32 !== 1'b0) begin fails++; $display("FAIL skid_full: got tag=%0d rdy=%0d want 1/0", t32, rdy32); end
        tests++; if (t0 !== 5'd1) begin fails++; $display("FAIL noskid_stable: got tag=%0d want 1", t0); end
        tag = 5'd3; instr = 32'hFE112E23;
        cyc();
        tests++; if (t32 !== 5'd1 || rdy32 !== 1'b0 || imm32 !== 32'hFFFFFFFF || f32 !== 3'd1) begin fails++; $display("FAIL skid_stable: got tag=%0d rdy=%0d imm=%h fmt=%0d want 1/0/ffffffff/1", t32, rdy32, imm32, f32); end
        out_ready = 1'b1;
        cyc();
        tests++; if (v32 !== 1'b1 || t32 !== 5'd2 || rdy32 !== 1'b1) begin fails++; $display("FAIL skid_k2o: got v=%0d tag=%0d rdy=%0d want 1/2/1", v32, t32, rdy32); end
        cyc();
        in_valid = 1'b0;
        tests++; if (v32 !== 1'b1 || t32 !== 5'd3 || f32 !== 3'd2) begin fails++; $display("FAIL skid_third: got v=%0d tag=%0d fmt=%0d want 1/3/2", v32, t32, f32); end
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL skid_empty: got %0d want 0", v32); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; tag = 5'd10;
        cyc();
        tag = 5'd11;
        cyc();
        tests++; if (rdy32 !== 1'b0) begin fails++; $display("FAIL flush_prefill: got rdy=%0d want 0", rdy32); end
        flush = 1'b1; tag = 5'd12;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (v32 !== 1'b0 || rdy32 !== 1'b1) begin fails++; $display("FAIL flush_clear32: got v=%0d rdy=%0d want 0/1", v32, rdy32); end
        tests++; if (v64 !== 1'b0 || v0 !== 1'b0 || rdy0 !== 1'b1) begin fails++; $display("FAIL flush_clear_other: got v64=%0d v0=%0d rdy0=%0d want 0/0/1", v64, v0, rdy0); end
        out_ready = 1'b1;
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL flush_no_ghost: got v=%0d tag=%0d want v=0", v32, t32); end
        in_valid = 1'b1; flush = 1'b1; tag = 5'd13;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (v32 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL flush_priority: got v32=%0d v0=%0d want 0/0", v32, v0); end
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL flush_priority_late: got %0d want 0", v32); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFE112E23; tag = 5'd20;
        cyc();
        tag = 5'd21;
        cyc();
        in_valid = 1'b0;
        tests++; if (v32 !== 1'b1 || rdy32 !== 1'b0) begin fails++; $display("FAIL areset_prefill: got v=%0d rdy=%0d want 1/0", v32, rdy32); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (v32 !== 1'b0 || v64 !== 1'b0) begin fails++; $display("FAIL areset_async: got v32=%0d v64=%0d want 0/0", v32, v64); end
        tests++; if (imm32 !== 32'h0 || f32 !== 3'd0 || t32 !== 5'd0 || rdy32 !== 1'b1) begin fails++; $display("FAIL areset_values: got imm=%h fmt=%0d tag=%0d rdy=%0d want 0/0/0/1", imm32, f32, t32, rdy32); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        tests++; if (v32 !== 1'b0 || imm32 !== 32'h0 || f32 !== 3'd0 || rdy32 !== 1'b1) begin fails++; $display("FAIL areset_release: got v=%0d imm=%h fmt=%0d rdy=%0d want 0/0/0/1", v32, imm32, f32, rdy32); end
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFFDFF06F; tag = 5'd22;
        cyc();
        in_valid = 1'b0;
        tests++; if (v32 !== 1'b1 || t32 !== 5'd22 || imm32 !== 32'hFFFFFFFC || f32 !== 3'd5) begin fails++; $display("FAIL areset_first: got v=%0d tag=%0d imm=%h fmt=%0d want 1/22/fffffffc/5", v32, t32, imm32, f32); end
        cyc();
        tests++; if (v32 !== 1'b0) begin fails++; $display("FAIL areset_drain: got %0d want 0", v32); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_decode();
        test_skid();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
